// File: rtl/i2c_slave_regfile_if.sv
// Register-side port bundle of the I2C responder:
// write strobe out, local debug read port in/out.
interface i2c_slave_regfile_if #(
    parameter int AW = 4
);
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    modport slave (
        output wr_valid, wr_addr, wr_data, rd_data,
        input  rd_addr
    );

    modport master (
        input  wr_valid, wr_addr, wr_data, rd_data,
        output rd_addr
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C target with pointer-addressed byte register file.
// Oversamples SCL/SDA on clk, drives SDA open-drain.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         DEPTH      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scl,
    inout  wire                sda,
    i2c_slave_regfile_if.slave regs,
    output logic               busy,
    output logic               erro_nack
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, MEM,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t        state, state_n;
    logic [2:0]    scl_sh, sda_sh;
    logic [2:0]    cnt, cnt_n;
    logic          full, full_n;
    logic [7:0]    sr, sr_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          sda_oe, oe_n;
    logic          busy_n, rw, rw_n;
    logic          wv_r, wv_n;
    logic [AW-1:0] wa_r, wa_n;
    logic [7:0]    wd_r, wd_n;
    logic          nack_n, we;
    logic [7:0]    mem [DEPTH];

    logic scl_s, scl_p, sda_s, sda_p;
    logic scl_rise, scl_fall, start_c, stop_c;
    logic rx, last;
    logic [7:0] byte_in;

    assign scl_s    = scl_sh[1];
    assign scl_p    = scl_sh[2];
    assign sda_s    = sda_sh[1];
    assign sda_p    = sda_sh[2];
    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    assign start_c  = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_c   = scl_s & scl_p & ~sda_p & sda_s;
    assign byte_in  = {sr[6:0], sda_s};
    assign last     = (cnt == 3'd7);
    // shift in only while a byte is still incomplete
    assign rx = scl_rise & ~full &
                ((state == ADDR) | (state == MEM) | (state == WDATA));

    assign sda           = sda_oe ? 1'b0 : 1'bz;
    assign regs.wr_valid = wv_r;
    assign regs.wr_addr  = wa_r;
    assign regs.wr_data  = wd_r;
    assign regs.rd_data  = mem[regs.rd_addr];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        full_n  = full;
        sr_n    = sr;
        ptr_n   = ptr;
        oe_n    = sda_oe;
        busy_n  = busy;
        rw_n    = rw;
        wv_n    = 1'b0;
        wa_n    = wa_r;
        wd_n    = wd_r;
        nack_n  = 1'b0;
        we      = 1'b0;
        if (stop_c || start_c) begin
            state_n = stop_c ? IDLE : ADDR;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            full_n  = 1'b0;
            cnt_n   = '0;
        end else begin
            if (rx) begin
                sr_n   = byte_in;
                cnt_n  = cnt + 3'd1;
                full_n = last;
            end
            unique case (state)
                ADDR: begin
                    if (rx && last) begin
                        if (byte_in[7:1] == SLAVE_ADDR) begin
                            busy_n = 1'b1;
                            rw_n   = byte_in[0];
                        end else begin
                            state_n = IDLE;
                            full_n  = 1'b0;
                        end
                    end else if (full && scl_fall) begin
                        oe_n    = 1'b1;
                        full_n  = 1'b0;
                        state_n = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_n = '0;
                        if (rw) begin
                            sr_n    = mem[ptr];
                            oe_n    = ~mem[ptr][7];
                            state_n = RDATA;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = MEM;
                        end
                    end
                end
                MEM: begin
                    if (rx && last) begin
                        ptr_n = byte_in[AW-1:0];
                    end else if (full && scl_fall) begin
                        oe_n    = 1'b1;
                        full_n  = 1'b0;
                        state_n = WDATA_ACK;
                    end
                end
                WDATA: begin
                    if (rx && last) begin
                        we    = 1'b1;
                        wv_n  = 1'b1;
                        wa_n  = ptr;
                        wd_n  = byte_in;
                        ptr_n = ptr + 1'b1;
                    end else if (full && scl_fall) begin
                        oe_n    = 1'b1;
                        full_n  = 1'b0;
                        state_n = WDATA_ACK;
                    end
                end
                WDATA_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = WDATA;
                    end
                end
                RDATA: begin
                    // MSB went out on entry; cnt counts bits 6..0
                    if (scl_fall) begin
                        if (last) begin
                            oe_n    = 1'b0;
                            state_n = RDATA_ACK;
                        end else begin
                            oe_n  = ~sr[6];
                            sr_n  = {sr[6:0], 1'b0};
                            cnt_n = cnt + 3'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && !full) begin
                        if (!sda_s) begin
                            ptr_n  = ptr + 1'b1;
                            full_n = 1'b1;
                        end else begin
                            nack_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end else if (full && scl_fall) begin
                        full_n  = 1'b0;
                        cnt_n   = '0;
                        sr_n    = mem[ptr];
                        oe_n    = ~mem[ptr][7];
                        state_n = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sh    <= 3'b111;
            sda_sh    <= 3'b111;
            state     <= IDLE;
            cnt       <= '0;
            full      <= 1'b0;
            sr        <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            wv_r      <= 1'b0;
            wa_r      <= '0;
            wd_r      <= '0;
            erro_nack <= 1'b0;
        end else begin
            scl_sh    <= {scl_sh[1:0], scl};
            sda_sh    <= {sda_sh[1:0], sda};
            state     <= state_n;
            cnt       <= cnt_n;
            full      <= full_n;
            sr        <= sr_n;
            ptr       <= ptr_n;
            sda_oe    <= oe_n;
            busy      <= busy_n;
            rw        <= rw_n;
            wv_r      <= wv_n;
            wa_r      <= wa_n;
            wd_r      <= wd_n;
            erro_nack <= nack_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[ptr] <= byte_in;
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master against i2c_slave_regfile.
// Tracks wr_valid / erro_nack pulses and checks hand-computed values.
module tb_i2c_slave_regfile;
    localparam int Q = 4;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda;
    logic busy, erro_nack;

    int n_chk = 0;
    int n_fail = 0;
    int nack_cnt = 0;
    logic [3:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic       ack;
    logic [7:0] d0, d1;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_regfile_if #(.AW(4)) rgi ();

    i2c_slave_regfile #(
        .SLAVE_ADDR(7'h50),
        .DEPTH     (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .regs     (rgi),
        .busy     (busy),
        .erro_nack(erro_nack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rgi.wr_valid) begin
            wa_q.push_back(rgi.wr_addr);
            wd_q.push_back(rgi.wr_data);
        end
        if (erro_nack) nack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wclk(Q);
        scl = 1'b1;   wclk(Q);
        m_low = 1'b1; wclk(Q);
        scl = 1'b0;   wclk(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wclk(Q);
        scl = 1'b1;   wclk(Q);
        m_low = 1'b0; wclk(H);
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b; wclk(Q);
        scl = 1'b1; wclk(H);
        scl = 1'b0; wclk(Q);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; wclk(Q);
        scl = 1'b1;   wclk(H / 2);
        b = sda;      wclk(H / 2);
        scl = 1'b0;   wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        a = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic a);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(~a);
    endtask

    task automatic peek(input logic [3:0] a, input logic [7:0] exp,
                        input string tag);
        rgi.rd_addr = a;
        #1;
        check(tag, rgi.rd_data, exp);
    endtask

    initial begin
        rgi.rd_addr = '0;
        wclk(3);
        check("rst_busy", busy, 0);
        check("rst_sda", sda, 1);
        check("rst_wv", rgi.wr_valid, 0);
        check("rst_wa", rgi.wr_addr, 0);
        check("rst_wd", rgi.wr_data, 0);
        check("rst_nack", erro_nack, 0);
        peek(4'd0, 8'h00, "rst_mem0");
        rst_n = 1'b1;
        wclk(4);

        // write 0x11,0x22 starting at pointer 3
        i2c_start();
        write_byte(8'hA0, ack); check("w_ack_addr", ack, 1);
        check("w_busy", busy, 1);
        write_byte(8'h03, ack); check("w_ack_ptr", ack, 1);
        write_byte(8'h11, ack); check("w_ack_d0", ack, 1);
        write_byte(8'h22, ack); check("w_ack_d1", ack, 1);
        i2c_stop();
        check("w_busy_stop", busy, 0);
        check("w_wv_cnt", wa_q.size(), 2);
        check("w_wa0", wa_q[0], 3);
        check("w_wd0", wd_q[0], 8'h11);
        check("w_wa1", wa_q[1], 4);
        check("w_wd1", wd_q[1], 8'h22);
        peek(4'd3, 8'h11, "w_mem3");
        peek(4'd4, 8'h22, "w_mem4");

        // set pointer, repeated start, read two bytes
        i2c_start();
        write_byte(8'hA0, ack); check("r_ack_addr", ack, 1);
        write_byte(8'h03, ack); check("r_ack_ptr", ack, 1);
        i2c_start();
        write_byte(8'hA1, ack); check("r_ack_raddr", ack, 1);
        read_byte(d0, 1'b1);
        read_byte(d1, 1'b0);
        check("r_d0", d0, 8'h11);
        check("r_d1", d1, 8'h22);
        check("r_busy_nack", busy, 0);
        check("r_nack_cnt", nack_cnt, 1);
        i2c_stop();
        check("r_no_wv", wa_q.size(), 2);

        // pointer wrap
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack);
        write_byte(8'hAA, ack); check("wr_ack_aa", ack, 1);
        write_byte(8'hBB, ack); check("wr_ack_bb", ack, 1);
        i2c_stop();
        check("wr_wa2", wa_q[2], 15);
        check("wr_wa3", wa_q[3], 0);
        peek(4'd15, 8'hAA, "wr_mem15");
        peek(4'd0, 8'hBB, "wr_mem0");

        // pointer byte 0x13 truncates to 3
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h13, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        read_byte(d0, 1'b0);
        i2c_stop();
        check("wr_trunc", d0, 8'h11);
        check("wr_nack_cnt", nack_cnt, 2);

        // address mismatch
        i2c_start();
        write_byte(8'hA2, ack); check("mm_ack", ack, 0);
        check("mm_busy", busy, 0);
        write_byte(8'h05, ack); check("mm_ack1", ack, 0);
        write_byte(8'h77, ack);
        i2c_stop();
        check("mm_no_wv", wa_q.size(), 4);
        peek(4'd5, 8'h00, "mm_mem5");

        // abort after four data bits
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h06, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        check("ab_no_wv", wa_q.size(), 4);
        check("ab_busy", busy, 0);
        peek(4'd6, 8'h00, "ab_mem6");
        i2c_start();
        write_byte(8'hA0, ack); check("ab_ack_next", ack, 1);
        write_byte(8'h06, ack);
        write_byte(8'h5A, ack); check("ab_ack_data", ack, 1);
        i2c_stop();
        check("ab_wa4", wa_q[4], 6);
        check("ab_wd4", wd_q[4], 8'h5A);

        // async reset while the slave drives ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
        m_low = 1'b0;
        wclk(Q);
        check("rs_ack_drv", sda, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rs_sda_rel", sda, 1);
        check("rs_busy", busy, 0);
        peek(4'd3, 8'h00, "rs_mem3");
        peek(4'd15, 8'h00, "rs_mem15");
        peek(4'd6, 8'h00, "rs_mem6");
        wclk(2);
        rst_n = 1'b1;
        scl = 1'b1;
        wclk(H);
        i2c_start();
        write_byte(8'hA0, ack); check("rs_ack_after", ack, 1);
        i2c_stop();
        check("rs_wv_total", wa_q.size(), 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
I2C responder (target) paired with the team's I2C master. Decodes START/STOP, matches a 7-bit device address, and ACKs. Write transfers: first byte sets the memory pointer, later bytes are stored in an internal byte register file. Read transfers: bytes are returned from the pointer with auto-increment. Runs entirely on system clk by oversampling SCL/SDA; drives SDA open-drain (low or Z only).

Parameters:
SLAVE_ADDR, 7'h50, device address matched against the first 7 bits after START
DEPTH, 16, register file size in bytes (power of 2, 2..256)
AW, $clog2(DEPTH), pointer width (derived)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
scl  input  1  I2C clock from master
sda  inout  1  I2C data; slave drives 1'b0 or 1'bz only
wr_valid  output  1  one-cycle pulse per data byte stored
wr_addr  output  AW  register index of stored byte
wr_data  output  8  stored byte
rd_addr  input  AW  local debug read index
rd_data  output  8  mem[rd_addr], combinational
busy  output  1  high from address match until STOP/START/mismatch
erro_nack  output  1  one-cycle pulse when master NACKs a read byte

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. On reset: all mem bytes 0, pointer 0, state IDLE, SDA released (Z), wr_valid=0, wr_addr=0, wr_data=0, busy=0, erro_nack=0.
- Input conditioning: scl and sda each pass through a 2-FF synchronizer, then a previous-value register. Derived signals:
  - scl_rise / scl_fall: edges of synced SCL.
  - START: synced SDA 1->0 while synced SCL=1.
  - STOP: synced SDA 0->1 while synced SCL=1.
- Detection latency is 3 clk. Each SCL phase (high and low) must last at least 4 clk.
- Bit timing:
  - Received bits are sampled on scl_rise, MSB first.
  - Slave-driven bits (ACK, read data) change only on scl_fall.
- Bit counter: 0..7 in data states, cleared on state entry.
- States:
  - IDLE: SDA released. START -> ADDR.
  - ADDR: shift 8 bits {addr[6:0], rw}. After the 8th scl_rise:
    - if addr==SLAVE_ADDR: set busy; on the next scl_fall drive SDA=0 and go to ADDR_ACK.
    - else: go to IDLE (no ACK, SDA stays Z).
  - ADDR_ACK: at the next scl_fall, release SDA.
    - rw=0 -> MEM.
    - rw=1 -> RDATA; mem[ptr] is loaded into the shift register and its MSB is driven on that same scl_fall.
  - MEM: receive 8 bits. ptr <= byte[AW-1:0] (upper bits ignored). ACK as in ADDR_ACK, then -> WDATA.
  - WDATA: receive 8 bits. On the 8th scl_rise:
    - mem[ptr] <= byte.
    - wr_valid pulses one clk with wr_addr=ptr and wr_data=byte.
    - ptr <= ptr+1, wrapping DEPTH-1 -> 0.
    - ACK on the next scl_fall -> WDATA_ACK; the scl_fall after that releases SDA -> WDATA.
  - RDATA: drive bit 7..0 on successive scl_falls. Drive 0 as SDA=0, drive 1 as Z. After the 8th bit's scl_fall, release SDA -> RDATA_ACK.
  - RDATA_ACK: sample SDA at scl_rise.
    - 0 (ACK): ptr <= ptr+1 (wrap); at the next scl_fall load mem[new ptr], drive its MSB, -> RDATA.
    - 1 (NACK): pulse erro_nack, clear busy, -> IDLE.
- STOP in any state: release SDA, clear busy, -> IDLE within 1 clk of detection. A partial byte is discarded (no mem write, no wr_valid).
- START in any state (repeated start): release SDA, clear bit counter, -> ADDR. The pointer is kept, so write-pointer-then-repeated-start-read returns mem[ptr].
- A START/STOP detected in the same clk as scl_rise takes priority over the bit sample.
- Pointer persists across transactions and changes only via MEM or auto-increment.
- rd_data is a combinational read. The local read port never conflicts with the I2C side; a same-cycle write to rd_addr shows the new value the next clk.
- Asynchronous reset mid-transfer: immediately release SDA and return to IDLE. The master sees NACK/bus idle.

Test Plan:
- Write: START, 0xA0 (0x50 write), 0x03, 0x11, 0x22, STOP → ACK on each of 4 bytes. wr_valid pulses twice: (3, 0x11), then (4, 0x22). rd_addr=3 gives 0x11; rd_addr=4 gives 0x22.
- Read with pointer set: START, 0xA0, 0x03, repeated START, 0xA1, master reads 2 bytes (ACK, then NACK), STOP → slave returns 0x11, 0x22. erro_nack pulses once. busy falls at the NACK.
- Pointer wrap: write pointer 0x0F, data 0xAA, 0xBB → mem[15]=0xAA, mem[0]=0xBB. Pointer byte 0x13 with DEPTH=16 → pointer becomes 3.
- Address mismatch: START, 0xA2 (0x51) → SDA stays Z on 9th clock. busy=0. No wr_valid for the following bytes until the next START.
- Abort: STOP after 4 bits of a WDATA byte → no wr_valid; state IDLE. The next transaction to 0x50 ACKs normally.
- Reset: assert rst_n=0 while slave drives ACK → SDA=Z within same cycle; mem all 0; busy=0.
